// File: rtl/traffic_light_pkg.sv
`default_nettype none
// ============================================================================
// Module   : traffic_light_pkg
// Purpose  : Shared encodings for the traffic-light sequencer and its monitor:
//            phase encoding, error-code encoding, decoded lamp states, and
//            default per-phase dwell constants.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package traffic_light_pkg;

  typedef enum logic [1:0] {
    PH_IDLE  = 2'd0,
    PH_RED   = 2'd1,
    PH_GREEN = 2'd2,
    PH_AMBER = 2'd3
  } phase_e;

  typedef enum logic [2:0] {
    ERR_NONE  = 3'd0,
    ERR_ORDER = 3'd1,
    ERR_SHORT = 3'd2,
    ERR_LONG  = 3'd3,
    ERR_DARK  = 3'd4,
    ERR_MULTI = 3'd5
  } err_code_e;

  typedef enum logic [2:0] {
    LAMP_RED   = 3'd0,
    LAMP_GREEN = 3'd1,
    LAMP_AMBER = 3'd2,
    LAMP_DARK  = 3'd3,
    LAMP_MULTI = 3'd4
  } lamp_e;

  localparam int C_RED_TICKS   = 350;
  localparam int C_GREEN_TICKS = 200;
  localparam int C_AMBER_TICKS = 10;

  // Classify one sample of the three lamp lines.
  function automatic lamp_e decode_lamp(input logic red, input logic amber,
                                        input logic green);
    case ({red, amber, green})
      3'b100:  return LAMP_RED;
      3'b010:  return LAMP_AMBER;
      3'b001:  return LAMP_GREEN;
      3'b000:  return LAMP_DARK;
      default: return LAMP_MULTI;
    endcase
  endfunction

  // Legal successor of a lit phase: RED -> GREEN -> AMBER -> RED.
  function automatic phase_e next_phase(input phase_e ph);
    case (ph)
      PH_RED:   return PH_GREEN;
      PH_GREEN: return PH_AMBER;
      PH_AMBER: return PH_RED;
      default:  return PH_IDLE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_light_monitor_dwell_counter.sv
`default_nettype none
// ============================================================================
// Module   : tl_dwell_counter
// Purpose  : Saturating dwell counter with window comparison against a
//            target T and tolerance TOL.
// Ports    : clock, reset_n   - clock, async active-low reset
//            i_clr            - force count to 0
//            i_restart        - load count with 1 (first sample of a phase)
//            i_inc            - saturating increment
//            i_target         - nominal dwell T of the current phase
//            o_count          - current count
//            short_o          - count < T-TOL
//            long_o           - count == T+TOL
// Revision : 1.0 - initial release
// ============================================================================
module tl_dwell_counter #(
  parameter int CNT_W = 16,
  parameter int TOL   = 0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_clr,
  input  logic             i_restart,
  input  logic             i_inc,
  input  logic [CNT_W-1:0] i_target,
  output logic [CNT_W-1:0] o_count,
  output logic             short_o,
  output logic             long_o
);

  // Window bounds are formed one bit wider so T+TOL cannot wrap.
  localparam logic [CNT_W:0] c_tol_ext = (CNT_W+1)'(TOL);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W:0]   w_lo;
  logic [CNT_W:0]   w_hi;
  logic [CNT_W:0]   w_count_ext;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_restart) begin
      r_count <= CNT_W'(1);
    end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  always_comb begin
    w_count_ext = {1'b0, r_count};
    w_lo        = {1'b0, i_target} - c_tol_ext;
    w_hi        = {1'b0, i_target} + c_tol_ext;
    short_o     = (w_count_ext < w_lo);
    long_o      = (w_count_ext == w_hi);
  end

  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/traffic_light_monitor.sv
`default_nettype none
// ============================================================================
// Module   : traffic_light_monitor
// Purpose  : Passive checker for the traffic-light lamp lines. Tracks the
//            phase sequence, measures dwell per phase, flags ORDER / SHORT /
//            LONG / DARK / MULTI errors and counts fully legal cycles.
// Ports    : clock, reset_n        - clock, async active-low reset
//            red, amber, green     - lamp lines, sampled on posedge clock
//            clear_err             - clears sticky err / err_code
//            phase[1:0]            - 0 IDLE, 1 RED, 2 GREEN, 3 AMBER
//            dwell_cnt[CNT_W-1:0]  - samples of the current lamp
//            err_pulse             - one-cycle strobe per error
//            err, err_code[2:0]    - sticky first-error flag and code
//            cycle_done            - one-cycle strobe per legal cycle
//            cycle_count[15:0]     - wrapping count of legal cycles
// Revision : 1.0 - initial release
// ============================================================================
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int RED_TICKS   = C_RED_TICKS,
  parameter int GREEN_TICKS = C_GREEN_TICKS,
  parameter int AMBER_TICKS = C_AMBER_TICKS,
  parameter int TOL         = 0,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             red,
  input  logic             amber,
  input  logic             green,
  input  logic             clear_err,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] dwell_cnt,
  output logic             err_pulse,
  output logic             err,
  output logic [2:0]       err_code,
  output logic             cycle_done,
  output logic [15:0]      cycle_count
);

  phase_e           r_phase, w_phase_nxt;
  lamp_e            w_lamp;
  phase_e           w_lamp_phase;
  // r_partial: current cycle began mid-stream, so its red dwell is unknown.
  // r_clean:   every check of the current cycle has passed so far.
  // r_long_seen: LONG already reported for this phase (guards saturation).
  logic             r_partial, w_partial_nxt;
  logic             r_clean, w_clean_nxt;
  logic             r_long_seen, w_long_seen_nxt;
  logic             w_cnt_clr, w_cnt_restart, w_cnt_inc;
  logic             w_err_fire;
  err_code_e        w_err_new;
  logic             w_done;
  logic [CNT_W-1:0] w_target;
  logic             w_short, w_long;

  logic             r_err_pulse;
  logic             r_err;
  err_code_e        r_err_code;
  logic             r_cycle_done;
  logic [15:0]      r_cycle_count;

  tl_dwell_counter #(
    .CNT_W (CNT_W),
    .TOL   (TOL)
  ) u_dwell (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_clr     (w_cnt_clr),
    .i_restart (w_cnt_restart),
    .i_inc     (w_cnt_inc),
    .i_target  (w_target),
    .o_count   (dwell_cnt),
    .short_o   (w_short),
    .long_o    (w_long)
  );

  always_comb begin
    w_lamp = decode_lamp(red, amber, green);
    case (w_lamp)
      LAMP_RED:   w_lamp_phase = PH_RED;
      LAMP_GREEN: w_lamp_phase = PH_GREEN;
      LAMP_AMBER: w_lamp_phase = PH_AMBER;
      default:    w_lamp_phase = PH_IDLE;
    endcase
    case (r_phase)
      PH_GREEN: w_target = CNT_W'(GREEN_TICKS);
      PH_AMBER: w_target = CNT_W'(AMBER_TICKS);
      default:  w_target = CNT_W'(RED_TICKS);
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_phase     <= PH_IDLE;
      r_partial   <= 1'b0;
      r_clean     <= 1'b0;
      r_long_seen <= 1'b0;
    end else begin
      r_phase     <= w_phase_nxt;
      r_partial   <= w_partial_nxt;
      r_clean     <= w_clean_nxt;
      r_long_seen <= w_long_seen_nxt;
    end
  end

  always_comb begin
    w_phase_nxt     = r_phase;
    w_partial_nxt   = r_partial;
    w_clean_nxt     = r_clean;
    w_long_seen_nxt = r_long_seen;
    w_cnt_clr       = 1'b0;
    w_cnt_restart   = 1'b0;
    w_cnt_inc       = 1'b0;
    w_err_fire      = 1'b0;
    w_err_new       = ERR_NONE;
    w_done          = 1'b0;

    if (r_phase == PH_IDLE) begin
      // Only red alone resynchronises; dark or multi-lit lamps are ignored.
      if (w_lamp == LAMP_RED) begin
        w_phase_nxt     = PH_RED;
        w_cnt_restart   = 1'b1;
        w_partial_nxt   = 1'b1;
        w_clean_nxt     = 1'b0;
        w_long_seen_nxt = 1'b0;
      end
    end else if (w_lamp == LAMP_MULTI) begin
      w_err_fire  = 1'b1;
      w_err_new   = ERR_MULTI;
      w_phase_nxt = PH_IDLE;
      w_cnt_clr   = 1'b1;
    end else if (w_lamp == LAMP_DARK) begin
      w_err_fire  = 1'b1;
      w_err_new   = ERR_DARK;
      w_phase_nxt = PH_IDLE;
      w_cnt_clr   = 1'b1;
    end else if (w_lamp_phase == r_phase) begin
      w_cnt_inc = 1'b1;
      if (w_long && !r_long_seen) begin
        w_err_fire      = 1'b1;
        w_err_new       = ERR_LONG;
        w_long_seen_nxt = 1'b1;
        w_clean_nxt     = 1'b0;
      end
    end else if (w_lamp_phase == next_phase(r_phase)) begin
      w_phase_nxt     = w_lamp_phase;
      w_cnt_restart   = 1'b1;
      w_long_seen_nxt = 1'b0;
      w_partial_nxt   = 1'b0;
      if (!r_partial && w_short) begin
        w_err_fire  = 1'b1;
        w_err_new   = ERR_SHORT;
        w_clean_nxt = 1'b0;
      end
      if (r_phase == PH_AMBER) begin
        // Closing a cycle: the amber check happens on this same edge.
        w_done      = r_clean && !w_short;
        w_clean_nxt = 1'b1;
      end
    end else begin
      w_err_fire  = 1'b1;
      w_err_new   = ERR_ORDER;
      w_phase_nxt = PH_IDLE;
      w_cnt_clr   = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_err_pulse   <= 1'b0;
      r_err         <= 1'b0;
      r_err_code    <= ERR_NONE;
      r_cycle_done  <= 1'b0;
      r_cycle_count <= '0;
    end else begin
      r_err_pulse  <= w_err_fire;
      r_cycle_done <= w_done;
      if (w_done) begin
        r_cycle_count <= r_cycle_count + 16'd1;
      end
      // A new error wins over a simultaneous clear; otherwise first error sticks.
      if (w_err_fire && (!r_err || clear_err)) begin
        r_err      <= 1'b1;
        r_err_code <= w_err_new;
      end else if (clear_err) begin
        r_err      <= 1'b0;
        r_err_code <= ERR_NONE;
      end
    end
  end

  assign phase       = r_phase;
  assign err_pulse   = r_err_pulse;
  assign err         = r_err;
  assign err_code    = r_err_code;
  assign cycle_done  = r_cycle_done;
  assign cycle_count = r_cycle_count;

endmodule
`default_nettype wire
